// File: rtl/load_buffer.sv
// load_buffer: in-order load buffer between address calculation, memory and CDB.
// Loads are allocated at tail, issue one read at a time at the issue pointer,
// and retire to the CDB from head, all in allocation order.
// Optional feature macro: LB_CDB_BYPASS_EN forwards granted memory data straight
// to the CDB in the grant cycle when the granted entry is also the head entry.

`ifndef XLEN
`define XLEN 32
`endif

package lb_pkg;

  typedef struct packed {
    logic             valid;
    logic [`XLEN-1:0] address;
    logic [4:0]       rd_tag;
    logic [2:0]       mem_size;
    logic [`XLEN-1:0] NPC;
    logic [`XLEN-1:0] inst;
  } LB_PACKET;

  typedef struct packed {
    logic             valid;
    logic [`XLEN-1:0] value;
    logic [4:0]       rob_tag;
    logic [`XLEN-1:0] NPC;
    logic [`XLEN-1:0] inst;
  } EX_WR_PACKET;

endpackage

module load_buffer
  import lb_pkg::*;
#(
  parameter int LB_DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  LB_PACKET         lb_packet_in,
  input  logic             squash,
  output logic             lb_full,
  output logic             lb2mem_req,
  output logic [`XLEN-1:0] lb2mem_addr,
  input  logic             mem2lb_grant,
  input  logic [`XLEN-1:0] mem2lb_data,
  output EX_WR_PACKET      lb_cdb_out,
  input  logic             cdb_grant
);

  localparam int PTR_W = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {EMPTY, WAIT_MEM, DONE} entry_state_t;

  entry_state_t     state    [LB_DEPTH];
  logic [`XLEN-1:0] addr_q   [LB_DEPTH];
  logic [2:0]       size_q   [LB_DEPTH];
  logic [4:0]       tag_q    [LB_DEPTH];
  logic [`XLEN-1:0] npc_q    [LB_DEPTH];
  logic [`XLEN-1:0] inst_q   [LB_DEPTH];
  logic [`XLEN-1:0] value_q  [LB_DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] issue;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic             alloc;
  logic             mem_grant;
  logic             pop;
  logic             flush;
  logic [`XLEN-1:0] mem_value;

  // Select and extend the addressed byte/halfword; misaligned accesses simply
  // use the truncated offset, and unknown sizes return the whole word.
  function automatic logic [`XLEN-1:0] extract(input logic [`XLEN-1:0] word,
                                               input logic [1:0]       off,
                                               input logic [2:0]       f3);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  extract = {{24{b[7]}}, b};
      3'b100:  extract = {24'b0, b};
      3'b001:  extract = {{16{h[15]}}, h};
      3'b101:  extract = {16'b0, h};
      default: extract = word;
    endcase
  endfunction

  assign flush       = reset | squash;
  assign lb_full     = ~reset & (count == CNT_W'(LB_DEPTH));
  assign alloc       = lb_packet_in.valid & ~lb_full;
  assign lb2mem_req  = ~reset & (state[issue] == WAIT_MEM);
  assign lb2mem_addr = lb2mem_req ? {addr_q[issue][`XLEN-1:2], 2'b00} : '0;
  assign mem_grant   = lb2mem_req & mem2lb_grant;
  assign mem_value   = extract(mem2lb_data, addr_q[issue][1:0], size_q[issue]);
  assign pop         = lb_cdb_out.valid & cdb_grant;

  // Present the head entry to the CDB once its data is in (or, with bypass, as it arrives).
  always_comb begin
    lb_cdb_out = '0;
    if (!reset) begin
      if (state[head] == DONE) begin
        lb_cdb_out.valid   = 1'b1;
        lb_cdb_out.value   = value_q[head];
        lb_cdb_out.rob_tag = tag_q[head];
        lb_cdb_out.NPC     = npc_q[head];
        lb_cdb_out.inst    = inst_q[head];
      end
`ifdef LB_CDB_BYPASS_EN
      else if (mem_grant && (issue == head)) begin
        lb_cdb_out.valid   = 1'b1;
        lb_cdb_out.value   = mem_value;
        lb_cdb_out.rob_tag = tag_q[head];
        lb_cdb_out.NPC     = npc_q[head];
        lb_cdb_out.inst    = inst_q[head];
      end
`else
      else begin
        lb_cdb_out = '0;
      end
`endif
    end
  end

  // Entry states, pointers and occupancy; reset and squash both empty the buffer,
  // and a pop of the entry granted in the same cycle (bypass) lands it in EMPTY.
  always_ff @(posedge clock) begin
    if (flush) begin
      for (int i = 0; i < LB_DEPTH; i++) begin
        state[i] <= EMPTY;
      end
      head  <= '0;
      issue <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (alloc) begin
        state[tail] <= WAIT_MEM;
        tail        <= tail + 1'b1;
      end
      if (mem_grant) begin
        state[issue] <= DONE;
        issue        <= issue + 1'b1;
      end
      if (pop) begin
        state[head] <= EMPTY;
        head        <= head + 1'b1;
      end
      case ({alloc, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Per-entry payload: load description on allocate, extracted data on grant.
  always_ff @(posedge clock) begin
    if (!flush) begin
      if (alloc) begin
        addr_q[tail] <= lb_packet_in.address;
        size_q[tail] <= lb_packet_in.mem_size;
        tag_q[tail]  <= lb_packet_in.rd_tag;
        npc_q[tail]  <= lb_packet_in.NPC;
        inst_q[tail] <= lb_packet_in.inst;
      end
      if (mem_grant) begin
        value_q[issue] <= mem_value;
      end
    end
  end

  // Flag loads that arrive while the buffer is full; they are dropped.
  always_ff @(posedge clock) begin
    if (!flush) begin
      assert (!(lb_packet_in.valid && lb_full))
        else $warning("load_buffer: load dropped because the buffer is full");
    end
  end

endmodule

// File: tb/tb_load_buffer.sv
// tb_load_buffer: directed checks of load_buffer (default depth 4).
// Bypass-specific expectations follow LB_CDB_BYPASS_EN when it is defined.

module tb_load_buffer;
  import lb_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  LB_PACKET    lb_packet_in;
  logic        squash;
  logic        lb_full;
  logic        lb2mem_req;
  logic [31:0] lb2mem_addr;
  logic        mem2lb_grant;
  logic [31:0] mem2lb_data;
  EX_WR_PACKET lb_cdb_out;
  logic        cdb_grant;

  int vectors     = 0;
  int miscompares = 0;

  LB_PACKET idle_pkt;

  load_buffer #(.LB_DEPTH(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .lb_packet_in (lb_packet_in),
    .squash       (squash),
    .lb_full      (lb_full),
    .lb2mem_req   (lb2mem_req),
    .lb2mem_addr  (lb2mem_addr),
    .mem2lb_grant (mem2lb_grant),
    .mem2lb_data  (mem2lb_data),
    .lb_cdb_out   (lb_cdb_out),
    .cdb_grant    (cdb_grant)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clock = ~clock;

  function automatic LB_PACKET mk_pkt(input logic [31:0] a, input logic [2:0] f3,
                                      input logic [4:0] tag);
    LB_PACKET p;
    p.valid    = 1'b1;
    p.address  = a;
    p.rd_tag   = tag;
    p.mem_size = f3;
    p.NPC      = 32'h0000_1000 + (32'(tag) << 2);
    p.inst     = 32'h0000_0003 | (32'(tag) << 7);
    return p;
  endfunction

  task automatic applyStimulus(input LB_PACKET pkt, input logic gnt, input logic [31:0] data,
                               input logic cgnt, input logic sq, input logic rst);
    lb_packet_in = pkt;
    mem2lb_grant = gnt;
    mem2lb_data  = data;
    cdb_grant    = cgnt;
    squash       = sq;
    reset        = rst;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
      else begin
        miscompares++;
        $error("[TB] FAIL %s: observed %h expected %h", name, observed, expected);
      end
  endtask

  // One complete load: allocate, grant with data, check address and result, pop.
  task automatic runLoad(input string name, input logic [31:0] a, input logic [2:0] f3,
                         input logic [4:0] tag, input logic [31:0] data,
                         input logic [31:0] exp_addr, input logic [31:0] exp_val);
    applyStimulus(mk_pkt(a, f3, tag), 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(idle_pkt, 1'b1, data, 1'b0, 1'b0, 1'b0);
    checkOutput({name, "_addr"}, lb2mem_addr, exp_addr);
    tick();
    applyStimulus(idle_pkt, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    checkOutput({name, "_val"}, lb_cdb_out.value, exp_val);
    checkOutput({name, "_tag"}, 32'(lb_cdb_out.rob_tag), 32'(tag));
    tick();
    applyStimulus(idle_pkt, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput({name, "_gone"}, 32'(lb_cdb_out.valid), 32'h0);
  endtask

  // Directed sequence covering reset, extraction, fill/wrap, squash and reset priority.
  initial begin
    idle_pkt = '0;

    // Reset behaviour
    applyStimulus(idle_pkt, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("rst_full", 32'(lb_full), 32'h0);
    checkOutput("rst_req", 32'(lb2mem_req), 32'h0);
    checkOutput("rst_cdb_zero", 32'(|lb_cdb_out), 32'h0);
    tick();
    tick();
    applyStimulus(idle_pkt, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("post_rst_req", 32'(lb2mem_req), 32'h0);
    checkOutput("post_rst_cdb", 32'(lb_cdb_out.valid), 32'h0);

    // LB at 0x100, sign-extended byte, one cycle after grant
    applyStimulus(mk_pkt(32'h100, 3'b000, 5'd3), 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(idle_pkt, 1'b1, 32'h0000_00F0, 1'b0, 1'b0, 1'b0);
    checkOutput("lb_req", 32'(lb2mem_req), 32'h1);
    checkOutput("lb_addr", lb2mem_addr, 32'h100);
`ifdef LB_CDB_BYPASS_EN
    checkOutput("lb_grant_cycle_valid", 32'(lb_cdb_out.valid), 32'h1);
`else
    checkOutput("lb_grant_cycle_valid", 32'(lb_cdb_out.valid), 32'h0);
`endif
    tick();
    applyStimulus(idle_pkt, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("lb_valid", 32'(lb_cdb_out.valid), 32'h1);
    checkOutput("lb_value", lb_cdb_out.value, 32'hFFFF_FFF0);
    checkOutput("lb_tag", 32'(lb_cdb_out.rob_tag), 32'h3);
    checkOutput("lb_npc", lb_cdb_out.NPC, 32'h0000_100C);
    checkOutput("lb_req_done", 32'(lb2mem_req), 32'h0);
    applyStimulus(idle_pkt, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(idle_pkt, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("lb_popped", 32'(lb_cdb_out.valid), 32'h0);

    // Extraction by size and offset, including misaligned accesses
    runLoad("lhu_102", 32'h102, 3'b101, 5'd5, 32'hBEEF_1234, 32'h100, 32'h0000_BEEF);
    runLoad("lh_102", 32'h102, 3'b001, 5'd6, 32'hBEEF_1234, 32'h100, 32'hFFFF_BEEF);
    runLoad("lbu_103", 32'h103, 3'b100, 5'd7, 32'h80AB_CDEF, 32'h100, 32'h0000_0080);
    runLoad("lb_101", 32'h101, 3'b000, 5'd8, 32'h80AB_CDEF, 32'h100, 32'hFFFF_FFCD);
    runLoad("lb_102", 32'h102, 3'b000, 5'd9, 32'h807F_CDEF, 32'h100, 32'h0000_007F);
    runLoad("lw_106", 32'h106, 3'b010, 5'd11, 32'hCAFE_F00D, 32'h104, 32'hCAFE_F00D);
    runLoad("lh_101", 32'h101, 3'b001, 5'd12, 32'h1234_8765, 32'h100, 32'hFFFF_8765);
    runLoad("lhu_100", 32'h100, 3'b101, 5'd13, 32'h1234_8765, 32'h100, 32'h0000_8765);

    // Fill to full with no CDB grants
    for (int i = 0; i < 4; i++) begin
      applyStimulus(mk_pkt(32'(32'h300 + 4 * i), 3'b010, 5'(10 + i)), 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("fill_full", 32'(lb_full), 32'(i == 3));
    end
    applyStimulus(mk_pkt(32'h3F0, 3'b010, 5'd14), 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(idle_pkt, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("drop_still_full", 32'(lb_full), 32'h1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(idle_pkt, 1'b1, 32'(32'hA0 + i), 1'b0, 1'b0, 1'b0);
      checkOutput("fill_issue_addr", lb2mem_addr, 32'(32'h300 + 4 * i));
      tick();
    end
    applyStimulus(idle_pkt, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("fill_req_idle", 32'(lb2mem_req), 32'h0);
    checkOutput("fill_head_val", lb_cdb_out.value, 32'hA0);
    checkOutput("fill_head_tag", 32'(lb_cdb_out.rob_tag), 32'd10);
    applyStimulus(idle_pkt, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("full_before_pop", 32'(lb_full), 32'h1);
    tick();
    applyStimulus(idle_pkt, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("full_after_pop", 32'(lb_full), 32'h0);
    for (int i = 1; i < 4; i++) begin
      applyStimulus(idle_pkt, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      checkOutput("drain_val", lb_cdb_out.value, 32'(32'hA0 + i));
      checkOutput("drain_tag", 32'(lb_cdb_out.rob_tag), 32'(10 + i));
      applyStimulus(idle_pkt, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      tick();
    end
    applyStimulus(idle_pkt, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("drain_empty_cdb", 32'(lb_cdb_out.valid), 32'h0);
    checkOutput("drain_empty_req", 32'(lb2mem_req), 32'h0);

    // Six further loads walk the pointers around the ring
    for (int i = 0; i < 6; i++) begin
      runLoad("wrap", 32'(32'h400 + 4 * i), 3'b010, 5'(20 + i),
              32'(32'hD000_0000 + i), 32'(32'h400 + 4 * i), 32'(32'hD000_0000 + i));
    end

    // Allocate and pop in the same cycle keeps the count unchanged
    applyStimulus(mk_pkt(32'h700, 3'b010, 5'd1), 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(idle_pkt, 1'b1, 32'h1111_1111, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(mk_pkt(32'h704, 3'b010, 5'd2), 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("swap_pop_val", lb_cdb_out.value, 32'h1111_1111);
    tick();
    applyStimulus(idle_pkt, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("swap_req", 32'(lb2mem_req), 32'h1);
    checkOutput("swap_addr", lb2mem_addr, 32'h704);
    checkOutput("swap_cdb", 32'(lb_cdb_out.valid), 32'h0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(mk_pkt(32'(32'h708 + 4 * i), 3'b010, 5'(3 + i)), 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("swap_fill_full", 32'(lb_full), 32'(i == 2));
    end

    // Squash with a grant and an incoming load in the same cycle
    applyStimulus(mk_pkt(32'h7F0, 3'b010, 5'd9), 1'b1, 32'h5555_5555, 1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(idle_pkt, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("sq1_req", 32'(lb2mem_req), 32'h0);
    checkOutput("sq1_full", 32'(lb_full), 32'h0);
    checkOutput("sq1_cdb", 32'(lb_cdb_out.valid), 32'h0);

    // Three loads waiting, squash together with a memory grant
    for (int i = 0; i < 3; i++) begin
      applyStimulus(mk_pkt(32'(32'h500 + 4 * i), 3'b010, 5'(30 + i)), 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    applyStimulus(idle_pkt, 1'b1, 32'h9999_9999, 1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(idle_pkt, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("sq2_req", 32'(lb2mem_req), 32'h0);
    checkOutput("sq2_full", 32'(lb_full), 32'h0);
    checkOutput("sq2_cdb", 32'(lb_cdb_out.valid), 32'h0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(mk_pkt(32'(32'h600 + 4 * i), 3'b010, 5'(16 + i)), 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("sq2_refill_full", 32'(lb_full), 32'(i == 3));
    end
    applyStimulus(idle_pkt, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("sq2_refill_addr", lb2mem_addr, 32'h600);

    // Reset in the grant cycle, with squash also asserted
    applyStimulus(idle_pkt, 1'b1, 32'h7777_7777, 1'b0, 1'b1, 1'b1);
    checkOutput("rst_mid_req", 32'(lb2mem_req), 32'h0);
    checkOutput("rst_mid_cdb", 32'(|lb_cdb_out), 32'h0);
    tick();
    applyStimulus(idle_pkt, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_after_req", 32'(lb2mem_req), 32'h0);
    checkOutput("rst_after_cdb", 32'(lb_cdb_out.valid), 32'h0);
    checkOutput("rst_after_full", 32'(lb_full), 32'h0);

`ifdef LB_CDB_BYPASS_EN
    // Bypass: grant and CDB grant together retire the load in the grant cycle
    applyStimulus(mk_pkt(32'h200, 3'b010, 5'd7), 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(idle_pkt, 1'b1, 32'h1234_5678, 1'b1, 1'b0, 1'b0);
    checkOutput("byp_valid", 32'(lb_cdb_out.valid), 32'h1);
    checkOutput("byp_value", lb_cdb_out.value, 32'h1234_5678);
    checkOutput("byp_tag", 32'(lb_cdb_out.rob_tag), 32'd7);
    tick();
    applyStimulus(idle_pkt, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("byp_after_cdb", 32'(lb_cdb_out.valid), 32'h0);
    checkOutput("byp_after_req", 32'(lb2mem_req), 32'h0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(mk_pkt(32'(32'h210 + 4 * i), 3'b010, 5'(i)), 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("byp_fill_full", 32'(lb_full), 32'(i == 3));
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/load_buffer.md
LOAD_BUFFER -- requirements
Module: load_buffer

Interface
REQ-001 Parameter: LB_DEPTH, default 4, number of load entries (power of two, 2..16).
REQ-002 Port: clock  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high.
REQ-004 Port: lb_packet_in  input  LB_PACKET  load from address calculation unit; fields valid, address, rd_tag, mem_size (funct3), NPC, inst.
REQ-005 Port: squash  input  1  branch-mispredict flush.
REQ-006 Port: lb_full  output  1  no free entry; upstream holds the load.
REQ-007 Port: lb2mem_req  output  1  read request valid.
REQ-008 Port: lb2mem_addr  output  `XLEN  word-aligned address, {addr[31:2],2'b00}.
REQ-009 Port: mem2lb_grant  input  1  request accepted; data valid in the same cycle.
REQ-010 Port: mem2lb_data  input  `XLEN  aligned 32-bit word.
REQ-011 Port: lb_cdb_out  output  EX_WR_PACKET  completed load (valid, value, rob_tag, NPC, inst).
REQ-012 Port: cdb_grant  input  1  CDB accepts lb_cdb_out this cycle.

Function
REQ-013 Circular FIFO of LB_DEPTH entries; per-entry state EMPTY, WAIT_MEM, DONE; pointers: tail (alloc), issue (next mem request), head (next CDB output); count 0..LB_DEPTH.
REQ-014 Allocate: lb_packet_in.valid & ~lb_full -> entry at tail goes EMPTY->WAIT_MEM at the edge, tail+1 mod LB_DEPTH.
REQ-015 lb_full = (count == LB_DEPTH), from registered count only; no allocate-on-pop in the same cycle.
REQ-016 valid packet while lb_full is dropped and not stored; simulation assertion fires.
REQ-017 lb2mem_req = 1 iff entry at issue pointer is WAIT_MEM; requests strictly in allocation order, one outstanding at a time.
REQ-018 lb2mem_req & mem2lb_grant -> extracted data latched, entry WAIT_MEM->DONE, issue+1 at the edge; request held unchanged until granted.
REQ-019 Extraction by addr[1:0] and funct3: LB(000)/LBU(100) byte at offset addr[1:0]*8; LH(001)/LHU(101) halfword at addr[1]*16; LW(010) full word; 000/001 sign-extended, 100/101 zero-extended.
REQ-020 lb_cdb_out.valid = 1 iff head entry is DONE; value, rob_tag, NPC, inst from that entry; all-zero when invalid.
REQ-021 lb_cdb_out.valid & cdb_grant -> head entry DONE->EMPTY, head+1, count-1 at the edge; output held stable until granted.
REQ-022 Allocate and CDB pop in the same cycle -> count unchanged.
REQ-023 Pointer wrap at LB_DEPTH-1 -> 0.
REQ-024 squash -> all entries EMPTY, pointers and count 0 at the edge; a grant in the same cycle is discarded; incoming packet same cycle dropped; squash overrides all other events.
REQ-025 Misaligned address (LH/LHU addr[0]=1, LW addr[1:0]!=0) serviced as aligned access at the truncated offset; no exception.

Reset
REQ-026 reset -> all entries EMPTY, head/issue/tail/count = 0 at the next edge.
REQ-027 During and after reset: lb_full=0, lb2mem_req=0, lb_cdb_out all-zero.
REQ-028 reset asserted mid-request discards the grant and data of that cycle; reset has priority over squash.

Configuration
REQ-029 Macro LB_CDB_BYPASS_EN selects the grant-to-CDB path.
REQ-030 Macro defined: when issue == head and head is granted this cycle, lb_cdb_out presents extracted mem2lb_data combinationally the same cycle; if cdb_grant is also 1, entry goes WAIT_MEM->EMPTY directly (latency 0 after grant).
REQ-031 Macro undefined: data always lands in DONE first; lb_cdb_out.valid no earlier than the cycle after grant (latency 1).

Verification
REQ-032 Reset, then LB address 0x100, funct3 000, rd_tag 3; grant with data 0x000000F0 -> lb2mem_addr=0x100, cdb value 0xFFFFFFF0, rob_tag 3, one cycle after grant (bypass off).
REQ-033 LHU addr 0x102, data 0xBEEF1234 -> value 0x0000BEEF; LH same -> 0xFFFFBEEF.
REQ-034 Fill 4 loads with cdb_grant=0 -> lb_full=1 after 4th edge; 5th valid packet dropped; one CDB pop -> lb_full=0 next cycle; 6 further loads exercise pointer wrap, completions in allocation order.
REQ-035 3 entries in WAIT_MEM; squash in same cycle as mem2lb_grant -> next cycle count=0, lb2mem_req=0, lb_cdb_out.valid=0.
REQ-036 LB_CDB_BYPASS_EN defined, empty buffer, one LW addr 0x200, grant + cdb_grant in the same cycle with data 0x12345678 -> lb_cdb_out.valid=1 with value 0x12345678 that cycle; count=0 next cycle.
